// File: rtl/sigmoid_pkg.sv
// Shared definitions for the neuron sequencer: the FSM state encoding and the
// default address and group-count widths.
package sigmoid_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE, CLEAR, ISSUE, DRAIN, CAPTURE, DONE
  } state_t;
endpackage

// File: rtl/neuron_seq_counter.sv
// Group counter and address generator. It loads N and the base address, and
// each enabled cycle it steps the address and consumes one group.
module neuron_seq_counter #(
  parameter int ADDR_W = sigmoid_pkg::ADDR_W_DEF,
  parameter int CNT_W  = sigmoid_pkg::CNT_W_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic              enable,
  input  logic [CNT_W-1:0]  load_cnt,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              tc,
  output logic              zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt  <= '0;
      addr <= '0;
    end else if (load) begin
      cnt  <= load_cnt;
      addr <= load_addr;
    end else if (enable && cnt != '0) begin
      cnt  <= cnt - CNT_W'(1);
      addr <= addr + ADDR_W'(1);   // wraps modulo 2^ADDR_W
    end
  end

  // tc marks the last issue cycle: one group left.
  assign tc   = (cnt == CNT_W'(1));
  assign zero = (cnt == '0);
endmodule

// File: rtl/neuron_sequencer.sv
// Sequences one neuron evaluation: it clears the ALU, streams N weight/input
// groups from memory, drains the ALU adder pipeline and captures the result.
module neuron_sequencer
  import sigmoid_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_groups,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        bias_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [15:0]       weight_data,
  input  logic [15:0]       input_data,
  output logic [15:0]       alu_weights,
  output logic [15:0]       alu_inputs,
  output logic [3:0]        alu_bias,
  output logic              alu_clear,
  output logic              alu_accumulate,
  input  logic [4:0]        alu_out,
  output logic [4:0]        result,
  output logic              busy,
  output logic              done
);
  localparam int STAGES = 1;

  state_t            state;
  logic              drain_q;
  logic [STAGES:0]   vld_pipe;   // [0] operand valid, [1] accumulate
  logic              tc, zero;
  logic              cnt_load, cnt_en;

  assign cnt_load = (state == IDLE) && start;
  assign cnt_en   = (state == ISSUE) && !abort;

  neuron_seq_counter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (cnt_load),
    .enable    (cnt_en),
    .load_cnt  (num_groups),
    .load_addr (base_addr),
    .addr      (mem_addr),
    .tc        (tc),
    .zero      (zero)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      drain_q   <= 1'b0;
      vld_pipe  <= '0;
      mem_ren   <= 1'b0;
      alu_clear <= 1'b0;
      alu_bias  <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], mem_ren};
      alu_clear <= 1'b0;
      done      <= 1'b0;
      if (abort && state != IDLE) begin
        state    <= IDLE;
        mem_ren  <= 1'b0;
        busy     <= 1'b0;
        vld_pipe <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state     <= CLEAR;
            alu_bias  <= bias_in;
            alu_clear <= 1'b1;
            busy      <= 1'b1;
          end
          // N=0 still passes through DRAIN so completion always lands at N+5.
          CLEAR: begin
            drain_q <= 1'b0;
            if (!zero) begin
              state   <= ISSUE;
              mem_ren <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
          ISSUE: if (tc) begin
            state   <= DRAIN;
            mem_ren <= 1'b0;
          end
          DRAIN: begin
            if (drain_q) state <= CAPTURE;
            drain_q <= 1'b1;
          end
          CAPTURE: begin
            result <= alu_out;
            state  <= DONE;
            done   <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read data returns one cycle after issue; gate it so the ALU sees zeros otherwise.
  assign alu_weights    = vld_pipe[0] ? weight_data : 16'h0000;
  assign alu_inputs     = vld_pipe[0] ? input_data  : 16'h0000;
  assign alu_accumulate = vld_pipe[STAGES];
endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench for neuron_sequencer: behavioural memory and ALU models, per-cycle
// timing checks and a result scoreboard popped on each done pulse.
module tb_neuron_sequencer;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0, abort = 1'b0;
  logic [CNT_W-1:0]  num_groups = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [3:0]        bias_in = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic [15:0]       weight_data = '0, input_data = '0;
  logic [15:0]       alu_weights, alu_inputs;
  logic [3:0]        alu_bias;
  logic              alu_clear, alu_accumulate;
  logic [4:0]        alu_out;
  logic [4:0]        result;
  logic              busy, done;

  int vectors = 0, miscompares = 0;
  logic [4:0] sb[$];
  logic [4:0] last_result = '0;

  neuron_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .num_groups(num_groups), .base_addr(base_addr), .bias_in(bias_in),
    .mem_addr(mem_addr), .mem_ren(mem_ren),
    .weight_data(weight_data), .input_data(input_data),
    .alu_weights(alu_weights), .alu_inputs(alu_inputs), .alu_bias(alu_bias),
    .alu_clear(alu_clear), .alu_accumulate(alu_accumulate), .alu_out(alu_out),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] wfn(input logic [ADDR_W-1:0] a);
    logic [15:0] w = '0;
    for (int j = 0; j < 4; j++) w[j*4 +: 4] = {3'b000, a[j]};
    return w;
  endfunction

  function automatic logic [15:0] ifn(input logic [ADDR_W-1:0] a);
    logic [15:0] v = '0;
    for (int j = 0; j < 4; j++) v[j*4 +: 4] = {2'b00, 2'(a[1:0] + 2'(j))};
    return v;
  endfunction

  function automatic int dot(input logic [15:0] w, input logic [15:0] v);
    int s = 0;
    for (int j = 0; j < 4; j++) s += int'(w[j*4 +: 4]) * int'(v[j*4 +: 4]);
    return s;
  endfunction

  // Memory with one-cycle read latency; garbage when not read.
  always @(posedge clk) begin
    if (mem_ren) begin
      weight_data <= wfn(mem_addr);
      input_data  <= ifn(mem_addr);
    end else begin
      weight_data <= 16'($urandom);
      input_data  <= 16'($urandom);
    end
  end

  // ALU: registered product stage, then accumulator; output = (acc+bias) mod 32.
  int prod = 0, acc_m = 0;
  always @(posedge clk) begin
    prod <= dot(alu_weights, alu_inputs);
    if (alu_clear) acc_m <= 0;
    else if (alu_accumulate) acc_m <= acc_m + prod;
  end
  always_comb alu_out = 5'(acc_m + int'(alu_bias));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [4:0] model(input int n, input logic [ADDR_W-1:0] base,
                                       input logic [3:0] bias);
    int s = int'(bias);
    for (int k = 0; k < n; k++) begin
      logic [ADDR_W-1:0] a = base + ADDR_W'(k);
      s += dot(wfn(a), ifn(a));
    end
    return 5'(s);
  endfunction

  task automatic run(input int n, input logic [ADDR_W-1:0] base,
                     input logic [3:0] bias, input bit hold);
    int done_cnt = 0, both = 0;
    logic [ADDR_W-1:0] a;
    sb.push_back(model(n, base, bias));
    @(negedge clk);
    num_groups = CNT_W'(n); base_addr = base; bias_in = bias; start = 1'b1;
    for (int c = 1; c <= n + 9; c++) begin
      @(negedge clk);
      if (c == 1) chk("clear_c1", alu_clear, 1);
      else        chk("clear_off", alu_clear, 0);
      a = base + ADDR_W'(c - 2);
      chk("mem_ren", mem_ren, (c >= 2 && c <= n + 1));
      if (c >= 2 && c <= n + 1) chk("mem_addr", mem_addr, a);
      a = base + ADDR_W'(c - 3);
      chk("alu_weights", alu_weights, (c >= 3 && c <= n + 2) ? wfn(a) : 16'h0);
      chk("accumulate", alu_accumulate, (c >= 4 && c <= n + 3));
      chk("done", done, (c == n + 5));
      chk("busy", busy, (c <= n + 5));
      if (c <= n + 5) chk("alu_bias", alu_bias, bias);
      if (alu_clear && alu_accumulate) both++;
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          last_result = sb.pop_front();
          chk("result", result, last_result);
        end
      end
      if (!hold || c == n + 5) start = 1'b0;
    end
    chk("done_count", done_cnt, 1);
    chk("clear_and_acc", both, 0);
    chk("result_hold", result, last_result);
  endtask

  task automatic run_abort();
    int acc_cnt = 0, done_cnt = 0;
    @(negedge clk);
    num_groups = 8'd5; base_addr = 10'h200; bias_in = 4'h2; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) begin
        chk("abort_busy_pre", busy, 1);
        abort = 1'b1;
      end
      if (c == 4) begin
        chk("abort_busy", busy, 0);
        chk("abort_ren", mem_ren, 0);
        abort = 1'b0;
      end
      if (c >= 4) begin
        acc_cnt += int'(alu_accumulate);
        done_cnt += int'(done);
      end
    end
    chk("abort_acc", acc_cnt, 0);
    chk("abort_done", done_cnt, 0);
    chk("abort_result", result, last_result);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    num_groups = 8'd4; base_addr = 10'h020; bias_in = 4'h9; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_ren", mem_ren, 1);
    n_rst = 1'b0;
    #1;
    chk("rst_addr", mem_addr, 0);
    chk("rst_ren", mem_ren, 0);
    chk("rst_w", alu_weights, 0);
    chk("rst_i", alu_inputs, 0);
    chk("rst_bias", alu_bias, 0);
    chk("rst_clear", alu_clear, 0);
    chk("rst_acc", alu_accumulate, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    last_result = '0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_ren", mem_ren, 0);
    n_rst = 1'b1;
    @(negedge clk);
    run(3, 10'h010, 4'hA, 1'b0);
    run(0, 10'h000, 4'h3, 1'b0);
    run(4, 10'h3FE, 4'h1, 1'b0);
    run_abort();
    run(2, 10'h055, 4'h7, 1'b1);
    @(negedge clk);
    chk("hold_idle", busy, 0);
    reset_mid();
    run(2, 10'h100, 4'h5, 1'b0);
    run(7, 10'h3FC, 4'hF, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
